adaptive_traffic_light_controller: RTL and testbench

Parametrised, sensor-actuated two-way (NS/EW) intersection controller. It is the successor to the fixed-cycle controller. Green times are configurable with minimum/maximum extension, there is a latched pedestrian all-red walk phase, and a flashing maintenance mode. It sits at the top of the intersection design: it drives the NS/EW lamp buses directly and takes raw vehicle sensors, the pedestrian button and the mode input from the board.

---
 rtl/adaptive_traffic_light_controller.sv | 154 +++++++++++++++
 tb/tb_adaptive_traffic_light_controller.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/adaptive_traffic_light_controller.sv
// Sensor-actuated two-way intersection controller with min/max green extension,
// a latched pedestrian all-red walk phase and a flashing maintenance mode.
module adaptive_traffic_light_controller #(
    parameter int unsigned GREEN_MIN    = 8,
    parameter int unsigned GREEN_MAX    = 20,
    parameter int unsigned YELLOW_TIME  = 3,
    parameter int unsigned ALL_RED_TIME = 2,
    parameter int unsigned WALK_TIME    = 6,
    parameter int unsigned FLASH_HALF   = 4,
    parameter int unsigned CNT_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ns_car,
    input  logic       ew_car,
    input  logic       ped_req,
    input  logic       flash_mode,
    output logic [2:0] NS,
    output logic [2:0] EW,
    output logic       walk
);

    typedef enum logic [2:0] {
        GREEN_NS,
        YELLOW_NS,
        ALL_RED,
        PED_WALK,
        GREEN_EW,
        YELLOW_EW,
        FLASH
    } state_t;

    localparam logic [CNT_W-1:0] T_GMIN = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] T_GMAX = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] T_Y    = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] T_AR   = CNT_W'(ALL_RED_TIME - 1);
    localparam logic [CNT_W-1:0] T_W    = CNT_W'(WALK_TIME - 1);
    localparam logic [CNT_W-1:0] T_FH   = CNT_W'(FLASH_HALF - 1);

    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] timer, timer_nxt;
    logic [CNT_W-1:0] fcnt, fcnt_nxt;
    logic             next_ew, next_ew_nxt;
    logic             ns_dem, ns_dem_nxt;
    logic             ew_dem, ew_dem_nxt;
    logic             ped_pend, ped_pend_nxt;
    logic             blink, blink_nxt;
    logic             entering;
    logic [2:0]       ns_lamp_nxt, ew_lamp_nxt;
    logic             walk_nxt;
    state_t           dir_green;

    // Next-state, timers, demand latches and lamp decode of the upcoming state
    always_comb begin
        state_nxt   = state;
        next_ew_nxt = next_ew;
        blink_nxt   = blink;
        fcnt_nxt    = fcnt;
        dir_green   = next_ew ? GREEN_EW : GREEN_NS;

        case (state)
            GREEN_NS: if (flash_mode || (timer >= T_GMIN && (ew_dem || ped_pend) &&
                                         (!ns_car || timer >= T_GMAX)))
                          state_nxt = YELLOW_NS;
            YELLOW_NS: if (timer == T_Y) state_nxt = ALL_RED;
            ALL_RED:  if (timer == T_AR)
                          state_nxt = flash_mode ? FLASH : (ped_pend ? PED_WALK : dir_green);
            PED_WALK: if (timer == T_W) state_nxt = flash_mode ? FLASH : dir_green;
            GREEN_EW: if (flash_mode || (timer >= T_GMIN && (ns_dem || ped_pend) &&
                                         (!ew_car || timer >= T_GMAX)))
                          state_nxt = YELLOW_EW;
            YELLOW_EW: if (timer == T_Y) state_nxt = ALL_RED;
            FLASH:    if (!flash_mode) state_nxt = ALL_RED;
            default:  state_nxt = ALL_RED;
        endcase

        entering  = (state_nxt != state);
        timer_nxt = entering ? '0 : ((timer == '1) ? timer : timer + CNT_W'(1));

        if (entering && state_nxt == YELLOW_NS) next_ew_nxt = 1'b1;
        if (entering && state_nxt == YELLOW_EW) next_ew_nxt = 1'b0;
        if (state == FLASH && state_nxt == ALL_RED) next_ew_nxt = 1'b0;

        if (entering && state_nxt == FLASH) begin
            blink_nxt = 1'b1;
            fcnt_nxt  = '0;
        end else if (state == FLASH) begin
            if (fcnt == T_FH) begin
                blink_nxt = ~blink;
                fcnt_nxt  = '0;
            end else begin
                fcnt_nxt = fcnt + CNT_W'(1);
            end
        end

        // Clear on phase entry takes priority over a same-cycle set
        ns_dem_nxt   = (entering && state_nxt == GREEN_NS) ? 1'b0
                     : (ns_dem | (ns_car && state != GREEN_NS));
        ew_dem_nxt   = (entering && state_nxt == GREEN_EW) ? 1'b0
                     : (ew_dem | (ew_car && state != GREEN_EW));
        ped_pend_nxt = (entering && state_nxt == PED_WALK) ? 1'b0
                     : (ped_pend | (ped_req && state != PED_WALK));

        ns_lamp_nxt = LAMP_R;
        ew_lamp_nxt = LAMP_R;
        walk_nxt    = 1'b0;
        case (state_nxt)
            GREEN_NS:  ns_lamp_nxt = LAMP_G;
            YELLOW_NS: ns_lamp_nxt = LAMP_Y;
            GREEN_EW:  ew_lamp_nxt = LAMP_G;
            YELLOW_EW: ew_lamp_nxt = LAMP_Y;
            PED_WALK:  walk_nxt    = 1'b1;
            FLASH: begin
                ns_lamp_nxt = blink_nxt ? LAMP_Y : LAMP_OFF;
                ew_lamp_nxt = blink_nxt ? LAMP_R : LAMP_OFF;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ALL_RED;
            timer    <= '0;
            fcnt     <= '0;
            next_ew  <= 1'b0;
            ns_dem   <= 1'b0;
            ew_dem   <= 1'b0;
            ped_pend <= 1'b0;
            blink    <= 1'b1;
            NS       <= LAMP_R;
            EW       <= LAMP_R;
            walk     <= 1'b0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            fcnt     <= fcnt_nxt;
            next_ew  <= next_ew_nxt;
            ns_dem   <= ns_dem_nxt;
            ew_dem   <= ew_dem_nxt;
            ped_pend <= ped_pend_nxt;
            blink    <= blink_nxt;
            NS       <= ns_lamp_nxt;
            EW       <= ew_lamp_nxt;
            walk     <= walk_nxt;
        end
    end

endmodule

// File: tb/tb_adaptive_traffic_light_controller.sv
// Segment-table bench: each segment holds inputs for n cycles with the lamp pattern
// expected after each edge; expectations go through a scoreboard queue.
module tb_adaptive_traffic_light_controller;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] O = 3'b000;

    typedef struct {
        string      name;
        logic       rst, nsc, ewc, ped, flm;
        logic [2:0] ens, eew;
        logic       ewalk;
        int         n;
    } seg_t;

    typedef struct {
        string      name;
        int         step;
        logic [2:0] ns, ew;
        logic       walk;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, ns_car, ew_car, ped_req, flash_mode;
    logic [2:0] NS, EW;
    logic       walk;

    int   tests = 0;
    int   fails = 0;
    seg_t segs[$];
    exp_t sb[$];

    adaptive_traffic_light_controller dut (
        .clk(clk), .reset(reset), .ns_car(ns_car), .ew_car(ew_car),
        .ped_req(ped_req), .flash_mode(flash_mode), .NS(NS), .EW(EW), .walk(walk)
    );

    always #5 clk = ~clk;

    // Both directions green together must never be seen
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            tests++;
            if (NS[0] && EW[0]) begin
                fails++;
                $display("FAIL both_green: NS=%b EW=%b, required not both green", NS, EW);
            end
        end
    end

    task automatic add(input string nm, input logic rst, nsc, ewc, ped, flm,
                       input logic [2:0] ens, eew, input logic ewalk, input int n);
        segs.push_back('{nm, rst, nsc, ewc, ped, flm, ens, eew, ewalk, n});
    endtask

    task automatic prefix(input string nm, input logic nsc, ewc);
        add({nm, "_rst"}, 1, nsc, ewc, 0, 0, R, R, 0, 3);
        add({nm, "_rel"}, 0, nsc, ewc, 0, 0, R, R, 0, 1);
    endtask

    // Reset, then an ew_car pulse sampled at NS green timer 2, through to EW green entry
    task automatic to_ew_green(input string nm);
        prefix(nm, 0, 0);
        add({nm, "_nsg"},  0, 0, 0, 0, 0, G, R, 0, 3);
        add({nm, "_ewp"},  0, 0, 1, 0, 0, G, R, 0, 1);
        add({nm, "_nsg2"}, 0, 0, 0, 0, 0, G, R, 0, 4);
        add({nm, "_nsy"},  0, 0, 0, 0, 0, Y, R, 0, 3);
        add({nm, "_ar"},   0, 0, 0, 0, 0, R, R, 0, 2);
    endtask

    initial begin
        exp_t e;
        reset = 1'b1; ns_car = 1'b0; ew_car = 1'b0; ped_req = 1'b0; flash_mode = 1'b0;

        // 1: idle after reset rests in NS green
        prefix("t1", 0, 0);
        add("t1_rest", 0, 0, 0, 0, 0, G, R, 0, 50);

        // 2: short EW demand ends NS green at GREEN_MIN
        to_ew_green("t2");
        add("t2_ewg", 0, 0, 0, 0, 0, R, G, 0, 10);

        // 3: continuous demand both ways runs GREEN_MAX alternation
        prefix("t3", 1, 1);
        add("t3_nsg", 0, 1, 1, 0, 0, G, R, 0, 20);
        add("t3_nsy", 0, 1, 1, 0, 0, Y, R, 0, 3);
        add("t3_ar1", 0, 1, 1, 0, 0, R, R, 0, 2);
        add("t3_ewg", 0, 1, 1, 0, 0, R, G, 0, 20);
        add("t3_ewy", 0, 1, 1, 0, 0, R, Y, 0, 3);
        add("t3_ar2", 0, 1, 1, 0, 0, R, R, 0, 2);
        add("t3_nsg2", 0, 1, 1, 0, 0, G, R, 0, 20);

        // 4: pedestrian phase; a request during walk is ignored
        prefix("t4", 0, 0);
        add("t4_nsg",  0, 0, 0, 0, 0, G, R, 0, 3);
        add("t4_ped",  0, 0, 0, 1, 0, G, R, 0, 1);
        add("t4_nsg2", 0, 0, 0, 0, 0, G, R, 0, 4);
        add("t4_nsy",  0, 0, 0, 0, 0, Y, R, 0, 3);
        add("t4_ar",   0, 0, 0, 0, 0, R, R, 0, 2);
        add("t4_wk0",  0, 0, 0, 0, 0, R, R, 1, 1);
        add("t4_wkp",  0, 0, 0, 1, 0, R, R, 1, 1);
        add("t4_wk1",  0, 0, 0, 0, 0, R, R, 1, 4);
        add("t4_ewg",  0, 0, 0, 0, 0, R, G, 0, 12);

        // 5: flash request cuts EW green short, blinks, then resumes at NS
        to_ew_green("t5");
        add("t5_ewg",  0, 0, 0, 0, 0, R, G, 0, 4);
        add("t5_ewy",  0, 0, 0, 0, 1, R, Y, 0, 3);
        add("t5_ar",   0, 0, 0, 0, 1, R, R, 0, 2);
        add("t5_fon",  0, 0, 0, 0, 1, Y, R, 0, 4);
        add("t5_foff", 0, 0, 0, 0, 1, O, O, 0, 4);
        add("t5_fon2", 0, 0, 0, 0, 1, Y, R, 0, 4);
        add("t5_ar2",  0, 0, 0, 0, 0, R, R, 0, 2);
        add("t5_nsg",  0, 0, 0, 0, 0, G, R, 0, 5);

        // 6: reset during EW yellow with pending NS and pedestrian demand
        to_ew_green("t6");
        add("t6_ewg0", 0, 0, 0, 0, 0, R, G, 0, 1);
        add("t6_nsc",  0, 1, 0, 0, 0, R, G, 0, 1);
        add("t6_ped",  0, 0, 0, 1, 0, R, G, 0, 1);
        add("t6_ewg",  0, 0, 0, 0, 0, R, G, 0, 5);
        add("t6_ewy",  0, 0, 0, 0, 0, R, Y, 0, 1);
        add("t6_rst",  1, 0, 0, 0, 0, R, R, 0, 1);
        add("t6_rel",  0, 0, 0, 0, 0, R, R, 0, 1);
        add("t6_nsg",  0, 0, 0, 0, 0, G, R, 0, 12);

        foreach (segs[i]) begin
            for (int k = 0; k < segs[i].n; k++) begin
                reset      = segs[i].rst;
                ns_car     = segs[i].nsc;
                ew_car     = segs[i].ewc;
                ped_req    = segs[i].ped;
                flash_mode = segs[i].flm;
                sb.push_back('{segs[i].name, k, segs[i].ens, segs[i].eew, segs[i].ewalk});
                @(posedge clk);
                #1;
                e = sb.pop_front();
                tests++;
                if (NS !== e.ns || EW !== e.ew || walk !== e.walk) begin
                    fails++;
                    $display("FAIL %s[%0d]: got NS=%b EW=%b walk=%b, required NS=%b EW=%b walk=%b",
                             e.name, e.step, NS, EW, walk, e.ns, e.ew, e.walk);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
